// File: rtl/xlr8_xf_pkg.sv
// Shared types, bit positions and address-decode helper for the xlr8_xf_gen
// function-unit dispatcher.
package xlr8_xf_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } xf_state_e;

  localparam int XF_MAX_UNITS = 16;

  localparam int CTRL_START_BIT = 6;
  localparam int CTRL_IRQ_BIT   = 5;

  localparam int STAT_DONE_BIT   = 7;
  localparam int STAT_UNSUP_BIT  = 6;
  localparam int STAT_REJECT_BIT = 5;
  localparam int STAT_BUSY_BIT   = 4;

  localparam logic [7:0] DM_BASE = 8'h60;

  // Registers at or above DM_BASE live in data-memory space, the rest in I/O space.
  function automatic logic reg_access(input logic [7:0] reg_adr,
                                      input logic [5:0] io_adr,
                                      input logic       io_stb,
                                      input logic       dm_sel,
                                      input logic [7:0] dm_adr,
                                      input logic       dm_stb);
    if (reg_adr >= DM_BASE) return dm_sel && dm_stb && (dm_adr == reg_adr);
    return io_stb && (io_adr == reg_adr[5:0]);
  endfunction

endpackage

// File: rtl/xlr8_xf_latcnt.sv
// 8-bit latency counter: loads a unit's latency, decrements towards zero and
// flags when the count has run out.
module xlr8_xf_latcnt
  import xlr8_xf_pkg::*;
(
  input  logic       cp2,
  input  logic       ireset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset, so every register updates from the same pre-edge values.
  always_ff @(posedge cp2) begin
    if (!ireset)                    count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && count != 8'd0)  count <= count - 8'd1;
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/xlr8_xf_gen.sv
// Function-unit dispatcher: snapshots GPR operands, pulses a unit enable, waits
// its latency and captures the result. Optional interrupt: XLR8_XF_IRQ_EN.
module xlr8_xf_gen
  import xlr8_xf_pkg::*;
#(
  parameter int                     NUM_UNITS  = 8,
  parameter int                     DATA_W     = 32,
  parameter logic [NUM_UNITS*8-1:0] LATENCY    = {NUM_UNITS{8'd1}},
  parameter logic [7:0]             CTRL_ADR   = 8'h10,
  parameter logic [7:0]             STATUS_ADR = 8'h11,
  parameter logic [7:0]             R0_ADR     = 8'h0C,
  parameter int                     OPA_REG    = 22,
  parameter int                     OPB_REG    = 18
) (
  input  logic                        cp2,
  input  logic                        ireset,
  input  logic [5:0]                  adr,
  input  logic [7:0]                  dbus_in,
  output logic [7:0]                  dbus_out,
  input  logic                        iore,
  input  logic                        iowe,
  output logic                        out_en,
  input  logic [7:0]                  core_ramadr,
  input  logic                        core_ramre,
  input  logic                        core_ramwe,
  input  logic                        core_dm_sel,
  input  logic [255:0]                gprf,
  output logic [DATA_W-1:0]           xf_dataa,
  output logic [DATA_W-1:0]           xf_datab,
  output logic [NUM_UNITS-1:0]        xf_en,
  input  logic [NUM_UNITS*DATA_W-1:0] xf_result
`ifdef XLR8_XF_IRQ_EN
  ,
  output logic                        xf_irq
`endif
);

  localparam int NBYTES = DATA_W / 8;

  xf_state_e             state;
  logic [3:0]            unit_reg;
  logic                  st_done, st_unsup, st_reject, unsup_pend;
  logic [DATA_W-1:0]     result;
  logic                  cnt_zero;
  logic                  ctrl_we, ctrl_re, status_re;
  logic                  start_req, start_ok;
  logic [7:0]            wr_lat;
  logic [NUM_UNITS-1:0]  wr_en_vec;
  logic [DATA_W-1:0]     sel_result;
  logic [7:0]            ctrl_rd, status_rd;
  logic                  unused_bits;
`ifdef XLR8_XF_IRQ_EN
  logic                  irq_en;
`endif

  assign ctrl_we   = reg_access(CTRL_ADR, adr, iowe, core_dm_sel, core_ramadr, core_ramwe);
  assign ctrl_re   = reg_access(CTRL_ADR, adr, iore, core_dm_sel, core_ramadr, core_ramre);
  assign status_re = reg_access(STATUS_ADR, adr, iore, core_dm_sel, core_ramadr, core_ramre);

  assign start_req = ctrl_we && dbus_in[CTRL_START_BIT];
  // Out-of-range units never match below, so they look like latency 0 (unsupported).
  assign start_ok  = start_req && (state == ST_IDLE) && (wr_lat != 8'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_lat     = '0;
    wr_en_vec  = '0;
    sel_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (dbus_in[3:0] == i[3:0]) begin
        wr_lat       = LATENCY[8*i +: 8];
        wr_en_vec[i] = 1'b1;
      end
      if (unit_reg == i[3:0]) sel_result = xf_result[DATA_W*i +: DATA_W];
    end
  end

  xlr8_xf_latcnt u_latcnt (
    .cp2      (cp2),
    .ireset   (ireset),
    .load     (start_ok),
    .load_val (wr_lat),
    .dec      (state == ST_RUN),
    .zero     (cnt_zero)
  );

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      state      <= ST_IDLE;
      unit_reg   <= '0;
      xf_en      <= '0;
      xf_dataa   <= '0;
      xf_datab   <= '0;
      result     <= '0;
      st_done    <= 1'b0;
      st_unsup   <= 1'b0;
      st_reject  <= 1'b0;
      unsup_pend <= 1'b0;
`ifdef XLR8_XF_IRQ_EN
      irq_en     <= 1'b0;
`endif
    end else begin
      xf_en <= '0;
      // Read-to-clear comes first so a same-cycle completion overrides it.
      if (status_re && st_done) st_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (unsup_pend) begin
            st_done    <= 1'b1;
            st_unsup   <= 1'b1;
            unsup_pend <= 1'b0;
          end
          if (ctrl_we) begin
            unit_reg <= dbus_in[3:0];
`ifdef XLR8_XF_IRQ_EN
            irq_en   <= dbus_in[CTRL_IRQ_BIT];
`endif
            if (start_req) begin
              xf_dataa  <= gprf[8*OPA_REG +: DATA_W];
              xf_datab  <= gprf[8*OPB_REG +: DATA_W];
              st_done   <= 1'b0;
              st_unsup  <= 1'b0;
              st_reject <= 1'b0;
              if (start_ok) begin
                xf_en      <= wr_en_vec;
                unsup_pend <= 1'b0;
                state      <= ST_RUN;
              end else begin
                unsup_pend <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (start_req) st_reject <= 1'b1;
          if (cnt_zero) begin
            result   <= sel_result;
            st_done  <= 1'b1;
            st_unsup <= 1'b0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[3:0]         = unit_reg;
`ifdef XLR8_XF_IRQ_EN
    ctrl_rd[CTRL_IRQ_BIT] = irq_en;
`endif
    status_rd                  = '0;
    status_rd[STAT_DONE_BIT]   = st_done;
    status_rd[STAT_UNSUP_BIT]  = st_unsup;
    status_rd[STAT_REJECT_BIT] = st_reject;
    status_rd[STAT_BUSY_BIT]   = (state == ST_RUN);

    dbus_out = '0;
    out_en   = 1'b0;
    if (ctrl_re) begin
      dbus_out = ctrl_rd;
      out_en   = 1'b1;
    end
    if (status_re) begin
      dbus_out = status_rd;
      out_en   = 1'b1;
    end
    for (int i = 0; i < NBYTES; i++) begin
      if (reg_access(R0_ADR + 8'(i), adr, iore, core_dm_sel, core_ramadr, core_ramre)) begin
        dbus_out = result[8*i +: 8];
        out_en   = 1'b1;
      end
    end
  end

`ifdef XLR8_XF_IRQ_EN
  assign xf_irq = irq_en & st_done;
`endif

  // Only the operand windows of the register file and some ctrl bits are used.
  assign unused_bits = ^{gprf, dbus_in};

endmodule

// File: tb/tb_xlr8_xf_gen.sv
// Directed self-checking bench for xlr8_xf_gen (NUM_UNITS=8, DATA_W=32); the
// interrupt scenario is built when XLR8_XF_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_xlr8_xf_gen;

  localparam logic [5:0] CTRL = 6'h10;
  localparam logic [5:0] STAT = 6'h11;
  localparam logic [5:0] R0   = 6'h0C;
  // Units 7..0 latencies: 0,1,1,1,10,20,3,1
  localparam logic [63:0] LAT = {8'd0, 8'd1, 8'd1, 8'd1, 8'd10, 8'd20, 8'd3, 8'd1};
`ifdef XLR8_XF_IRQ_EN
  localparam logic [7:0] CTRL_23_EXP = 8'h23;
`else
  localparam logic [7:0] CTRL_23_EXP = 8'h03;
`endif

  logic         cp2 = 1'b0;
  logic         ireset;
  logic [5:0]   adr;
  logic [7:0]   dbus_in, dbus_out;
  logic         iore, iowe, out_en;
  logic [7:0]   core_ramadr;
  logic         core_ramre, core_ramwe, core_dm_sel;
  logic [255:0] gprf;
  logic [31:0]  xf_dataa, xf_datab;
  logic [7:0]   xf_en;
  logic [255:0] xf_result;
`ifdef XLR8_XF_IRQ_EN
  logic         xf_irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s;
  logic [7:0] v;
  logic       oe;

  xlr8_xf_gen #(
    .NUM_UNITS (8),
    .DATA_W    (32),
    .LATENCY   (LAT)
  ) dut (
    .cp2         (cp2),
    .ireset      (ireset),
    .adr         (adr),
    .dbus_in     (dbus_in),
    .dbus_out    (dbus_out),
    .iore        (iore),
    .iowe        (iowe),
    .out_en      (out_en),
    .core_ramadr (core_ramadr),
    .core_ramre  (core_ramre),
    .core_ramwe  (core_ramwe),
    .core_dm_sel (core_dm_sel),
    .gprf        (gprf),
    .xf_dataa    (xf_dataa),
    .xf_datab    (xf_datab),
    .xf_en       (xf_en),
    .xf_result   (xf_result)
`ifdef XLR8_XF_IRQ_EN
    ,
    .xf_irq      (xf_irq)
`endif
  );

  always #5 cp2 = ~cp2;
  always @(posedge cp2) cyc <= cyc + 1;

  // Each helper starts 1ns after a rising edge and returns 1ns after the next one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cp2);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    adr = a; dbus_in = d; iowe = 1'b1;
    @(posedge cp2);
    #1;
    iowe = 1'b0; dbus_in = 8'h00;
  endtask

  task automatic rd(input logic [5:0] a);
    adr = a; iore = 1'b1;
    #1;
    v  = dbus_out;
    oe = out_en;
    @(posedge cp2);
    #1;
    iore = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (xf_en !== 8'h00) begin errors++; $display("FAIL reset_xf_en: got %h want 00", xf_en); end
    checks++; if (xf_dataa !== 32'h0 || xf_datab !== 32'h0) begin
      errors++; $display("FAIL reset_operands: got %h/%h want 0/0", xf_dataa, xf_datab); end
    checks++; if (out_en !== 1'b0 || dbus_out !== 8'h00) begin
      errors++; $display("FAIL reset_bus_idle: got oe=%b d=%h want 0/00", out_en, dbus_out); end
    // CTRL_ADR is in I/O space, so a DM access at the same address must not hit it.
    core_dm_sel = 1'b1; core_ramre = 1'b1; core_ramadr = 8'h10;
    #1;
    checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL dm_no_decode: got oe=%b want 0", out_en); end
    core_dm_sel = 1'b0; core_ramre = 1'b0; core_ramadr = 8'h00;
    rd(STAT);
    checks++; if (v !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL reset_status: got %h oe=%b want 00 oe=1", v, oe); end
    rd(CTRL);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", v); end
  endtask

  task automatic test_basic;
    logic [31:0] exp_r;
    exp_r = 32'h40490FDB;
    wr(CTRL, 8'h41);
    checks++; if (xf_en !== 8'h02) begin errors++; $display("FAIL basic_xf_en: got %h want 02", xf_en); end
    checks++; if (xf_dataa !== 32'h3F800000) begin errors++; $display("FAIL basic_dataa: got %h want 3f800000", xf_dataa); end
    checks++; if (xf_datab !== 32'h40000000) begin errors++; $display("FAIL basic_datab: got %h want 40000000", xf_datab); end
    rd(R0);  // S+1: result not yet updated
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_prev_result: got %h want 00", v); end
    checks++; if (xf_en !== 8'h00) begin errors++; $display("FAIL basic_en_pulse: got %h want 00", xf_en); end
    rd(STAT);  // S+2
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL basic_busy_s2: got %h want 10", v); end
    tick(1);
    rd(STAT);  // S+4, last busy cycle
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL basic_busy_s4: got %h want 10", v); end
    rd(STAT);  // S+5
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL basic_done_s5: got %h want 80", v); end
    rd(STAT);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_done_clear: got %h want 00", v); end
    for (int i = 0; i < 4; i++) begin
      rd(R0 + 6'(i));
      checks++; if (v !== exp_r[8*i +: 8] || oe !== 1'b1) begin
        errors++; $display("FAIL basic_result_b%0d: got %h oe=%b want %h oe=1", i, v, oe, exp_r[8*i +: 8]); end
    end
    rd(CTRL);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL basic_ctrl_rd: got %h want 01", v); end
  endtask

  task automatic test_unsupported;
    logic [7:0] cmds [2];
    cmds[0] = 8'h47;
    cmds[1] = 8'h4C;
    for (int k = 0; k < 2; k++) begin
      wr(CTRL, cmds[k]);
      checks++; if (xf_en !== 8'h00) begin errors++; $display("FAIL unsup_xf_en_%h: got %h want 00", cmds[k], xf_en); end
      rd(STAT);  // S+1
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL unsup_s1_%h: got %h want 00", cmds[k], v); end
      rd(STAT);  // S+2
      checks++; if (v !== 8'hC0) begin errors++; $display("FAIL unsup_s2_%h: got %h want c0", cmds[k], v); end
    end
    rd(STAT);
    checks++; if (v !== 8'h40) begin errors++; $display("FAIL unsup_done_clear: got %h want 40", v); end
    rd(CTRL);
    checks++; if (v !== 8'h0C) begin errors++; $display("FAIL unsup_ctrl: got %h want 0c", v); end
  endtask

  task automatic test_busy_reject;
    logic [31:0] exp_r;
    int          done_cyc;
    exp_r    = 32'h12345678;
    done_cyc = -1;
    s = cyc;
    wr(CTRL, 8'h42);
    checks++; if (xf_en !== 8'h04) begin errors++; $display("FAIL rej_xf_en: got %h want 04", xf_en); end
    gprf[8*22 +: 32] = 32'h11111111;
    wr(CTRL, 8'h41);  // start while running
    checks++; if (xf_en !== 8'h00 || xf_dataa !== 32'h3F800000) begin
      errors++; $display("FAIL rej_ignored: got en=%h a=%h want 00/3f800000", xf_en, xf_dataa); end
    rd(STAT);
    checks++; if (v !== 8'h30) begin errors++; $display("FAIL rej_status: got %h want 30", v); end
    rd(CTRL);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL rej_ctrl: got %h want 02", v); end
    wr(CTRL, 8'h05);  // non-start write while running
    rd(CTRL);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL rej_ctrl_nonstart: got %h want 02", v); end
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      int c;
      c = cyc;
      rd(STAT);
      if (v[7]) done_cyc = c;
    end
    checks++; if (done_cyc != s + 22) begin errors++; $display("FAIL rej_done_cycle: got %0d want %0d", done_cyc - s, 22); end
    for (int i = 0; i < 4; i++) begin
      rd(R0 + 6'(i));
      checks++; if (v !== exp_r[8*i +: 8]) begin errors++; $display("FAIL rej_result_b%0d: got %h want %h", i, v, exp_r[8*i +: 8]); end
    end
    gprf[8*22 +: 32] = 32'h3F800000;
  endtask

  task automatic test_coincident;
    wr(CTRL, 8'h40);
    tick(1);
    rd(STAT);  // S+2: completion edge closes this cycle
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL coin_read: got %h want 10", v); end
    rd(STAT);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL coin_done: got %h want 80", v); end
    rd(STAT);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL coin_clear: got %h want 00", v); end
    rd(R0);
    checks++; if (v !== 8'h0D) begin errors++; $display("FAIL coin_result: got %h want 0d", v); end
  endtask

  task automatic test_reset_abort;
    int done_cyc;
    done_cyc = -1;
    wr(CTRL, 8'h43);
    checks++; if (xf_en !== 8'h08) begin errors++; $display("FAIL abort_xf_en: got %h want 08", xf_en); end
    tick(1);
    ireset = 1'b0;
    tick(1);
    ireset = 1'b1;
    checks++; if (xf_en !== 8'h00 || xf_dataa !== 32'h0 || xf_datab !== 32'h0) begin
      errors++; $display("FAIL abort_outputs: got en=%h a=%h b=%h want 0", xf_en, xf_dataa, xf_datab); end
    rd(STAT);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_status: got %h want 00", v); end
    rd(CTRL);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_ctrl: got %h want 00", v); end
    xf_result[32*3 +: 32] = 32'hCAFEF00D;
    tick(10);
    rd(STAT);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_late_status: got %h want 00", v); end
    rd(R0);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_no_capture: got %h want 00", v); end
    s = cyc;
    wr(CTRL, 8'h41);
    for (int k = 0; k < 20 && done_cyc < 0; k++) begin
      int c;
      c = cyc;
      rd(STAT);
      if (v[7]) done_cyc = c;
    end
    checks++; if (done_cyc != s + 5) begin errors++; $display("FAIL abort_restart_done: got %0d want %0d", done_cyc - s, 5); end
    rd(R0);
    checks++; if (v !== 8'hDB) begin errors++; $display("FAIL abort_restart_result: got %h want db", v); end
  endtask

  task automatic test_ctrl_write;
    wr(CTRL, 8'h23);
    rd(CTRL);
    checks++; if (v !== CTRL_23_EXP) begin errors++; $display("FAIL ctrl_nonstart: got %h want %h", v, CTRL_23_EXP); end
    rd(STAT);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ctrl_nonstart_status: got %h want 00", v); end
  endtask

`ifdef XLR8_XF_IRQ_EN
  task automatic test_irq;
    int rise_cyc;
    rise_cyc = -1;
    s = cyc;
    wr(CTRL, 8'h63);
    for (int k = 0; k < 30 && rise_cyc < 0; k++) begin
      if (xf_irq === 1'b1) rise_cyc = cyc;
      else tick(1);
    end
    checks++; if (rise_cyc != s + 12) begin errors++; $display("FAIL irq_rise: got %0d want %0d", rise_cyc - s, 12); end
    rd(STAT);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL irq_status: got %h want 80", v); end
    checks++; if (xf_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", xf_irq); end
    rd(CTRL);
    checks++; if (v !== 8'h23) begin errors++; $display("FAIL irq_ctrl: got %h want 23", v); end
  endtask
`endif

  initial begin
    ireset = 1'b0;
    adr = '0; dbus_in = '0; iore = 1'b0; iowe = 1'b0;
    core_ramadr = '0; core_ramre = 1'b0; core_ramwe = 1'b0; core_dm_sel = 1'b0;
    gprf = '0;
    gprf[8*22 +: 32] = 32'h3F800000;
    gprf[8*18 +: 32] = 32'h40000000;
    xf_result = {8{32'hFFFFFFFF}};
    xf_result[32*0 +: 32] = 32'h0BADF00D;
    xf_result[32*1 +: 32] = 32'h40490FDB;
    xf_result[32*2 +: 32] = 32'h12345678;
    xf_result[32*3 +: 32] = 32'hDEADBEEF;
    repeat (3) @(posedge cp2);
    #1;
    ireset = 1'b1;

    test_reset();
    test_basic();
    test_unsupported();
    test_busy_reject();
    test_coincident();
    test_reset_abort();
    test_ctrl_write();
`ifdef XLR8_XF_IRQ_EN
    test_irq();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/xlr8_xf_gen.md
# xlr8_xf_gen

Parametrised function-unit dispatcher between the AVR core and up to 16 user functional units (FP or integer). It snapshots operands from the register file, pulses the selected unit's enable, counts that unit's latency, captures its result and exposes control, status and result bytes on I/O or DM space. It replaces the fixed 8-unit/32-bit dispatcher, adding configurable width and unit count, busy-reject and an optional interrupt.

## Interface
- NUM_UNITS, 8: functional units, 1..16
- DATA_W, 32: operand/result width, 8/16/32
- LATENCY, {NUM_UNITS{8'd1}}: packed NUM_UNITS*8; unit i at [8i+:8]; 0 = unsupported
- CTRL_ADR, 8'h10; STATUS_ADR, 8'h11: register addresses
- R0_ADR, 8'h0C: result byte 0; byte i at R0_ADR+i
- OPA_REG, 22; OPB_REG, 18: lowest GPR of operand A/B
- Address >= 8'h60 selects DM decode (core_dm_sel, core_ramadr, core_ramre/we), else I/O decode (adr, iore/iowe)

Ports:
- cp2  in  1  clock
- ireset  in  1  reset; synchronous, active-low
- adr  in  6  I/O address
- dbus_in  in  8  write data
- dbus_out  out  8  read data, 0 when not selected
- iore, iowe  in  1  I/O strobes
- out_en  out  1  this block drives dbus_out
- core_ramadr  in  8; core_ramre, core_ramwe, core_dm_sel  in  1  DM decode
- gprf  in  256  register file, read-only
- xf_dataa, xf_datab  out  DATA_W  operand snapshots
- xf_en  out  NUM_UNITS  one-cycle start per unit
- xf_result  in  NUM_UNITS*DATA_W  unit i at [DATA_W*i+:DATA_W]
- xf_irq  out  1  completion interrupt (XLR8_XF_IRQ_EN only)

## Operation
- Ctrl: [7] reads 0; [6] start (write-only, reads 0); [5] irq enable (macro only, else 0); [4] 0; [3:0] unit.
- Status: [7] done; [6] unsupported; [5] busy-reject; [4] busy (live); [3:0] 0.
- States IDLE, RUN. Start write in IDLE: ctrl_reg updated; xf_dataa/xf_datab <= gprf[8*OPA_REG+:DATA_W]/gprf[8*OPB_REG+:DATA_W]; status cleared; supported unit -> RUN, counter <= LATENCY[unit].
- Unit >= NUM_UNITS or latency 0: no xf_en, stay IDLE, status <= 8'hC0 next cycle.
- RUN: counter decrements; at 0 capture selected xf_result into result, status <= 8'h80, -> IDLE.
- Start write in RUN: ignored (ctrl_reg, operands, counter unchanged); status[5] sets, sticky until next accepted start.
- Non-start ctrl write in IDLE updates ctrl_reg only; in RUN ignored.
- Status read with [7]=1 clears [7] next edge; completion in same cycle wins.
- Result bytes readable anytime; during RUN return previous result. Bytes >= DATA_W/8 undecoded.

## Timing
- Reset: dbus_out, out_en, xf_en, xf_dataa, xf_datab, result, ctrl_reg, status, counter all 0; xf_irq 0; state IDLE.
- Start written at cycle S: xf_en[u] high only in S+1 with operands valid; result sampled at end of S+1+L; status 8'h80 visible from S+2+L. Unsupported: 8'hC0 from S+2.
- Busy reads 1 from S+1 through S+1+L.
- Reads combinational, same cycle as strobe.
- ireset low mid-RUN aborts: IDLE, no capture, late unit result ignored.

## Configuration
- XLR8_XF_IRQ_EN defined: ctrl[5] writable; xf_irq = ctrl[5] & status[7], level, cleared by status read or next start.
- Undefined: no xf_irq port, ctrl[5] reads 0.

## Structure
- Package xlr8_xf_pkg: state enum, ctrl/status bit localparams, XF_MAX_UNITS=16.
- Sub-module xlr8_xf_latcnt: 8-bit load/decrement counter with zero flag.

## Test plan
- DATA_W=32, LATENCY[1]=3, R25..22=0x3F800000: write 0x41 at S -> xf_en=0x02 in S+1 only, xf_dataa=0x3F800000, status 0x80 at S+5, R0..R3 = unit result bytes.
- Unit 7 with LATENCY[7]=0, and unit 12 with NUM_UNITS=8 -> no xf_en, status 0xC0 at S+2.
- Start while RUN (LATENCY=20) -> status[5]=1, ctrl_reg unchanged, first op completes normally.
- Status read coincident with completion -> next status 0x80; following read clears to 0x00.
- ireset low at S+2 of 10-cycle op -> all outputs 0, no capture, new start works.
- IRQ_EN, ctrl 0x63 -> xf_irq rises with status[7], drops after status read.
